// File: rtl/ws2811_encoder.sv
// WS2811 NRZ serializer: bytes in over valid/ready, MSB first, one timed pulse per bit,
// with a one-byte skid buffer and an automatic latch (reset) low period when the stream runs dry.
// Parameters must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= BIT_CYC.
module ws2811_encoder #(
    parameter int T0H_CYC   = 4,
    parameter int T1H_CYC   = 8,
    parameter int BIT_CYC   = 13,
    parameter int RESET_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dout,
    output logic       busy,
    output logic       latch_done
);

    localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             dout_q, dout_d;
    logic             latch_done_q, latch_done_d;
    logic             xfer;

    assign in_ready   = ~hold_valid_q;
    assign xfer       = in_valid && in_ready;
    assign dout       = dout_q;
    assign busy       = (state_q != S_IDLE);
    assign latch_done = latch_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        latch_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A held byte has priority; in_ready is low then, so no transfer can race it.
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    state_d      = S_SEND;
                    cnt_d        = '0;
                    bit_idx_d    = 3'd7;
                end else if (xfer) begin
                    shift_d   = in_data;
                    state_d   = S_SEND;
                    cnt_d     = '0;
                    bit_idx_d = 3'd7;
                end
            end

            S_SEND: begin
                if (xfer) begin
                    hold_d       = in_data;
                    hold_valid_d = 1'b1;
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                    end else if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        bit_idx_d    = 3'd7;
                    end else if (xfer) begin
                        // Byte arriving on the boundary edge goes straight to the shifter.
                        shift_d      = in_data;
                        hold_valid_d = 1'b0;
                        bit_idx_d    = 3'd7;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_LATCH: begin
                if (xfer) begin
                    hold_d       = in_data;
                    hold_valid_d = 1'b1;
                end
                if (cnt_q == RST_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    latch_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Output is derived from next-state values so the registered line lines up with the bit slot.
        dout_d = (state_d == S_SEND) && (cnt_d < (shift_d[7] ? T1H : T0H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            hold_valid_q <= 1'b0;
            dout_q       <= 1'b0;
            latch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            hold_valid_q <= hold_valid_d;
            dout_q       <= dout_d;
            latch_done_q <= latch_done_d;
        end
    end

    // Data registers carry no reset; they are only consumed when qualified by state or hold_valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

endmodule

// File: tb/tb_ws2811_encoder.sv
// Self-checking bench for ws2811_encoder: a negedge monitor decodes the line into bytes and
// compares them against a queue of accepted bytes; scenario tasks check timing and handshake.
module tb_ws2811_encoder;

    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int BITC     = 13;
    localparam int RSTC     = 500;
    localparam int BYTE_CYC = 8 * BITC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       dout;
    logic       busy;
    logic       latch_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int latch_cnt = 0;
    logic [7:0] exp_q[$];

    ws2811_encoder #(
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .BIT_CYC  (BITC),
        .RESET_CYC(RSTC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .busy      (busy),
        .latch_done(latch_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor
    logic       m_prev = 1'b0;
    int         m_hi = 0;
    int         m_since = 0;
    bit         m_stream = 1'b0;
    int         m_nbits = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_bit;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev   = 1'b0;
            m_hi     = 0;
            m_since  = 0;
            m_stream = 1'b0;
            m_nbits  = 0;
            m_byte   = 8'h00;
        end else begin
            if (dout && !m_prev) begin
                if (m_stream) begin
                    checks++;
                    if (m_since != BITC) begin
                        failures++;
                        $display("FAIL bit_period: got %0d cycles between pulse starts, need %0d", m_since, BITC);
                    end
                end
                m_stream = 1'b1;
                m_since  = 0;
                m_hi     = 0;
            end
            if (dout) m_hi++;
            if (!dout && m_prev) begin
                checks++;
                m_bit = 1'b0;
                if (m_hi == T1H) m_bit = 1'b1;
                else if (m_hi != T0H) begin
                    failures++;
                    $display("FAIL pulse_width: got %0d high cycles, need %0d or %0d", m_hi, T0H, T1H);
                end
                m_byte = {m_byte[6:0], m_bit};
                m_nbits++;
                if (m_nbits == 8) begin
                    m_nbits = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL byte_out: got unexpected byte %02h, none queued", m_byte);
                    end else begin
                        m_exp = exp_q.pop_front();
                        if (m_byte !== m_exp) begin
                            failures++;
                            $display("FAIL byte_out: got %02h, need %02h", m_byte, m_exp);
                        end
                    end
                end
            end
            if (latch_done) begin
                latch_cnt++;
                checks++;
                if (m_since != BITC + RSTC) begin
                    failures++;
                    $display("FAIL latch_len: got %0d cycles from last pulse start to latch_done, need %0d", m_since, BITC + RSTC);
                end
                m_stream = 1'b0;
            end
            m_prev = dout;
            m_since++;
        end
    end

    // Offer a byte and hold in_valid until it transfers; acc is the edge count of the transfer.
    task automatic offer(input logic [7:0] b, output int acc);
        int i;
        acc = -1;
        i = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (in_ready) begin
            @(posedge clk);
            exp_q.push_back(b);
            #1;
            acc = cyc;
        end else begin
            checks++;
            failures++;
            $display("FAIL offer_timeout: byte %02h not accepted, need in_ready=1", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_latch(output int at);
        int i;
        at = -1;
        i = 0;
        while (at < 0 && i < 3000) begin
            @(posedge clk);
            #1;
            if (latch_done) at = cyc;
            i++;
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL latch_timeout: got no latch_done, need one");
        end
    endtask

    task automatic wait_until(input int target);
        int i;
        i = 0;
        while (cyc < target && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout !== 1'b0)       begin failures++; $display("FAIL rst_dout: got %b, need 0", dout); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy: got %b, need 0", busy); end
        checks++; if (latch_done !== 1'b0) begin failures++; $display("FAIL rst_latch_done: got %b, need 0", latch_done); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL rst_in_ready: got %b, need 1", in_ready); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_rst: got dout=%b busy=%b, need 0 0", dout, busy);
        end
    endtask

    task automatic test_single_byte();
        int a, at;
        offer(8'hA5, a);
        checks++; if (dout !== 1'b1) begin failures++; $display("FAIL single_latency: got dout=%b after accept, need 1", dout); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b, need 1", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b, need 1", in_ready); end
        wait_latch(at);
        checks++; if (at - a != BYTE_CYC + RSTC) begin
            failures++; $display("FAIL single_total: got %0d edges accept->latch_done, need %0d", at - a, BYTE_CYC + RSTC);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b, need 0", busy); end
        @(posedge clk);
        #1;
        checks++; if (latch_done !== 1'b0) begin failures++; $display("FAIL single_pulse_len: got latch_done=%b, need 0", latch_done); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain: got %0d bytes pending, need 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, at, l0;
        l0 = latch_cnt;
        offer(8'hFF, a1);
        offer(8'h00, a2);
        checks++; if (a2 - a1 != 1) begin failures++; $display("FAIL b2b_accept: got gap %0d, need 1", a2 - a1); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_held: got in_ready=%b, need 0", in_ready); end
        wait_latch(at);
        checks++; if (at - a1 != 2 * BYTE_CYC + RSTC) begin
            failures++; $display("FAIL b2b_total: got %0d, need %0d", at - a1, 2 * BYTE_CYC + RSTC);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (latch_cnt - l0 != 1) begin failures++; $display("FAIL b2b_latches: got %0d, need 1", latch_cnt - l0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d pending, need 0", exp_q.size()); end
    endtask

    task automatic test_back_pressure();
        int a1, a2, a3, at;
        offer(8'h01, a1);
        offer(8'h02, a2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_drop: got %b, need 0", in_ready); end
        offer(8'h03, a3);
        checks++; if (a3 - a1 != BYTE_CYC + 1) begin
            failures++; $display("FAIL bp_third_accept: got %0d edges after first, need %0d", a3 - a1, BYTE_CYC + 1);
        end
        wait_latch(at);
        checks++; if (at - a1 != 3 * BYTE_CYC + RSTC) begin
            failures++; $display("FAIL bp_total: got %0d, need %0d", at - a1, 3 * BYTE_CYC + RSTC);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d pending, need 0", exp_q.size()); end
    endtask

    task automatic test_byte_during_latch();
        int a1, a2, at, at2;
        offer(8'h80, a1);
        wait_until(a1 + BYTE_CYC + 100);
        checks++; if (busy !== 1'b1 || dout !== 1'b0) begin
            failures++; $display("FAIL latch_state: got busy=%b dout=%b, need 1 0", busy, dout);
        end
        offer(8'h55, a2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL latch_hold: got in_ready=%b, need 0", in_ready); end
        wait_latch(at);
        checks++; if (at - a1 != BYTE_CYC + RSTC) begin
            failures++; $display("FAIL latch_full: got %0d, need %0d", at - a1, BYTE_CYC + RSTC);
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL latch_idle_held: got busy=%b in_ready=%b, need 0 0", busy, in_ready);
        end
        @(posedge clk);
        #1;
        checks++; if (dout !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL latch_restart: got dout=%b busy=%b in_ready=%b, need 1 1 1", dout, busy, in_ready);
        end
        wait_latch(at2);
        checks++; if (at2 - at != 1 + BYTE_CYC + RSTC) begin
            failures++; $display("FAIL latch_second: got %0d, need %0d", at2 - at, 1 + BYTE_CYC + RSTC);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL latch_drain: got %0d pending, need 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int a, at;
        bit seen_hi;
        offer(8'hFF, a);
        wait_until(a + 4 * BITC + 2);
        checks++; if (dout !== 1'b1) begin failures++; $display("FAIL arst_pre: got dout=%b in bit 3 high phase, need 1", dout); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dout !== 1'b0) begin failures++; $display("FAIL arst_dout: got %b, need 0", dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b, need 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready: got %b, need 1", in_ready); end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_hi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dout || busy || latch_done) seen_hi = 1'b1;
        end
        checks++; if (seen_hi) begin failures++; $display("FAIL arst_residual: got activity after reset, need none"); end
        offer(8'h0F, a);
        wait_latch(at);
        checks++; if (at - a != BYTE_CYC + RSTC) begin
            failures++; $display("FAIL arst_resume: got %0d, need %0d", at - a, BYTE_CYC + RSTC);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL arst_drain: got %0d pending, need 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_back_pressure();
        test_byte_during_latch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, need finish");
        $fatal(1, "watchdog expired");
    end

endmodule
